// File: rtl/qec_round_sequencer.sv
// Round sequencer for the 5-qubit code: requests X/Y/Z syndromes, issues them to a
// fixed-latency decoder, folds corrections into a Pauli frame and publishes it.
module qec_round_sequencer #(
  parameter int NQ      = 5,
  parameter int SYN_W   = 4,
  parameter int DEC_LAT = 2,
  parameter int RND_W   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [RND_W-1:0] rounds,
  output logic             busy,
  output logic             meas_req,
  output logic [1:0]       meas_axis,
  input  logic             syn_valid,
  output logic             syn_ready,
  input  logic [SYN_W-1:0] syndrome,
  output logic             dec_valid,
  output logic [1:0]       dec_axis,
  output logic [SYN_W-1:0] dec_ancilla,
  input  logic [NQ-1:0]    dec_correction,
  output logic [NQ-1:0]    frame_x,
  output logic [NQ-1:0]    frame_z,
  output logic [3:0]       fail_count,
  output logic             frame_valid,
  input  logic             frame_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] AX_X = 2'd0;
  localparam logic [1:0] AX_Z = 2'd2;

  localparam int              WC_W    = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;
  localparam logic [WC_W-1:0] WC_LOAD = WC_W'(DEC_LAT - 1);

  logic [2:0]       state;
  logic [1:0]       axis;
  logic [RND_W-1:0] rcnt;
  logic [WC_W-1:0]  wcnt;

  assign busy        = (state != S_IDLE);
  assign meas_req    = (state == S_REQ);
  assign syn_ready   = (state == S_REQ);
  assign meas_axis   = axis;
  assign dec_valid   = (state == S_ISSUE);
  assign frame_valid = (state == S_DONE);

  // dec_axis/dec_ancilla double as the captured syndrome: loaded on the REQ
  // handshake, they are presented during ISSUE and hold until the next capture.
  // NOTE: all state below uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      axis        <= AX_X;
      rcnt        <= '0;
      wcnt        <= '0;
      dec_axis    <= AX_X;
      dec_ancilla <= '0;
      frame_x     <= '0;
      frame_z     <= '0;
      fail_count  <= '0;
    end else if (abort && (state != S_IDLE)) begin
      state <= S_IDLE;
      axis  <= AX_X;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (rounds != '0)) begin
            frame_x    <= '0;
            frame_z    <= '0;
            fail_count <= '0;
            axis       <= AX_X;
            rcnt       <= rounds;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (syn_valid) begin
            dec_ancilla <= syndrome;
            dec_axis    <= axis;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wcnt  <= WC_LOAD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - WC_W'(1);
          end else begin
            // Y corrections land in both halves of the frame.
            if (axis != AX_Z) frame_x <= frame_x ^ dec_correction;
            if (axis != AX_X) frame_z <= frame_z ^ dec_correction;
            if ((dec_ancilla != '0) && (dec_correction == '0) && (fail_count != 4'hF))
              fail_count <= fail_count + 4'd1;
            if (axis == AX_Z) begin
              axis  <= AX_X;
              rcnt  <= rcnt - RND_W'(1);
              state <= (rcnt == RND_W'(1)) ? S_DONE : S_REQ;
            end else begin
              axis  <= axis + 2'd1;
              state <= S_REQ;
            end
          end
        end
        S_DONE: begin
          if (frame_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qec_round_sequencer.sv
// Self-checking bench for qec_round_sequencer: front-end and DEC_LAT=2 decoder
// models, scoreboard queues for decoder issues and published frames.
module tb_qec_round_sequencer;
  localparam int NQ = 5, SYN_W = 4, DEC_LAT = 2, RND_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [RND_W-1:0] rounds = '0;
  logic             busy, meas_req, syn_ready, dec_valid, frame_valid;
  logic [1:0]       meas_axis, dec_axis;
  logic             syn_valid = 1'b0;
  logic [SYN_W-1:0] syndrome = '0;
  logic [SYN_W-1:0] dec_ancilla;
  logic [NQ-1:0]    dec_correction;
  logic [NQ-1:0]    frame_x, frame_z;
  logic [3:0]       fail_count;
  logic             frame_ready = 1'b0;

  qec_round_sequencer #(.NQ(NQ), .SYN_W(SYN_W), .DEC_LAT(DEC_LAT), .RND_W(RND_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .rounds(rounds),
    .busy(busy), .meas_req(meas_req), .meas_axis(meas_axis),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syndrome(syndrome),
    .dec_valid(dec_valid), .dec_axis(dec_axis), .dec_ancilla(dec_ancilla),
    .dec_correction(dec_correction), .frame_x(frame_x), .frame_z(frame_z),
    .fail_count(fail_count), .frame_valid(frame_valid), .frame_ready(frame_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] rounds;
    logic [3:0] sx, sy, sz;
    int         y_delay;
    int         ready_delay;
    bit         ready_pre;
    bit         chk_lat;
    logic [4:0] exp_fx, exp_fz;
    logic [3:0] exp_fail;
  } vec_t;
  typedef struct { logic [4:0] fx, fz; logic [3:0] fail; } frame_t;
  typedef struct { logic [1:0] ax; logic [3:0] anc; } issue_t;

  issue_t     issue_q[$];
  frame_t     frame_q[$];
  int         n_checks = 0, n_fail = 0;
  int         cyc = 0;
  int         issue_count = 0, last_issue = -1, req_y_cnt = 0;
  bit         chk_spacing = 1'b0;
  logic [3:0] syn_tab[4];
  int         y_delay = 0, y_wait = 0;
  logic [4:0] p1 = '0, p2 = '0;
  issue_t     mon_issue;
  frame_t     mon_frame;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] dec_map(input logic [1:0] ax, input logic [3:0] s);
    logic [4:0] c;
    c = 5'b00000;
    if (ax == 2'd0) begin
      case (s)
        4'b0001: c = 5'b10000;
        4'b1000: c = 5'b01000;
        4'b1100: c = 5'b00100;
        4'b0110: c = 5'b00010;
        4'b0011: c = 5'b00001;
        default: c = 5'b00000;
      endcase
    end else begin
      case (s)
        4'b1011: c = 5'b10000;
        4'b1101: c = 5'b01000;
        4'b1110: c = 5'b00100;
        4'b1111: c = 5'b00010;
        4'b0111: c = 5'b00001;
        default: c = 5'b00000;
      endcase
    end
    return c;
  endfunction

  function automatic vec_t mk(input logic [3:0] r, sx, sy, sz, input int yd, rd,
                              input bit pre, lat, input logic [4:0] fx, fz,
                              input logic [3:0] fl);
    vec_t v;
    v.rounds = r; v.sx = sx; v.sy = sy; v.sz = sz;
    v.y_delay = yd; v.ready_delay = rd; v.ready_pre = pre; v.chk_lat = lat;
    v.exp_fx = fx; v.exp_fz = fz; v.exp_fail = fl;
    return v;
  endfunction

  // Decoder: correction appears exactly DEC_LAT=2 cycles after the issue cycle.
  always @(posedge CLK) begin
    p1 <= dec_valid ? dec_map(dec_axis, dec_ancilla) : 5'b00000;
    p2 <= p1;
  end
  assign dec_correction = p2;

  always @(posedge CLK) cyc++;

  // Front end: syn_valid held high, except a programmable stall on the Y request.
  always @(posedge CLK) begin
    #1;
    if (meas_req && (meas_axis == 2'd1)) begin
      syn_valid = (y_wait >= y_delay);
      y_wait++;
    end else begin
      y_wait    = 0;
      syn_valid = 1'b1;
    end
    syndrome = syn_tab[meas_axis];
  end

  // Monitor on the falling edge, away from DUT updates.
  always @(negedge CLK) begin
    if (meas_req && (meas_axis == 2'd1)) req_y_cnt++;
    if (dec_valid) begin
      issue_count++;
      if (issue_q.size() == 0) begin
        check("dec_valid_unexpected", {31'd0, dec_valid}, 32'd0);
      end else begin
        mon_issue = issue_q.pop_front();
        check("dec_axis", {30'd0, dec_axis}, {30'd0, mon_issue.ax});
        check("dec_ancilla", {28'd0, dec_ancilla}, {28'd0, mon_issue.anc});
      end
      if (chk_spacing && (last_issue >= 0)) check("dec_spacing", cyc - last_issue, 32'd4);
      last_issue = cyc;
    end
    if (frame_valid) begin
      if (frame_q.size() == 0) begin
        check("frame_valid_unexpected", {31'd0, frame_valid}, 32'd0);
      end else begin
        mon_frame = frame_q[0];
        check("frame_x", {27'd0, frame_x}, {27'd0, mon_frame.fx});
        check("frame_z", {27'd0, frame_z}, {27'd0, mon_frame.fz});
        check("fail_count", {28'd0, fail_count}, {28'd0, mon_frame.fail});
        if (frame_ready) void'(frame_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_meas_req"}, {31'd0, meas_req}, 32'd0);
    check({tag, "_meas_axis"}, {30'd0, meas_axis}, 32'd0);
    check({tag, "_syn_ready"}, {31'd0, syn_ready}, 32'd0);
    check({tag, "_dec_valid"}, {31'd0, dec_valid}, 32'd0);
    check({tag, "_dec_axis"}, {30'd0, dec_axis}, 32'd0);
    check({tag, "_dec_ancilla"}, {28'd0, dec_ancilla}, 32'd0);
    check({tag, "_frame_x"}, {27'd0, frame_x}, 32'd0);
    check({tag, "_frame_z"}, {27'd0, frame_z}, 32'd0);
    check({tag, "_fail_count"}, {28'd0, fail_count}, 32'd0);
    check({tag, "_frame_valid"}, {31'd0, frame_valid}, 32'd0);
  endtask

  task automatic arm(input vec_t v);
    issue_t e;
    syn_tab[0] = v.sx; syn_tab[1] = v.sy; syn_tab[2] = v.sz; syn_tab[3] = 4'd0;
    y_delay = v.y_delay;
    for (int r = 0; r < int'(v.rounds); r++) begin
      for (int a = 0; a < 3; a++) begin
        e.ax  = 2'(a);
        e.anc = syn_tab[a];
        issue_q.push_back(e);
      end
    end
    issue_count = 0;
    last_issue  = -1;
    chk_spacing = (v.y_delay == 0);
    req_y_cnt   = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int     lat;
    bit     seen;
    frame_t f;
    arm(v);
    f.fx = v.exp_fx; f.fz = v.exp_fz; f.fail = v.exp_fail;
    frame_q.push_back(f);
    frame_ready = v.ready_pre;
    rounds = v.rounds;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      if (frame_valid) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    if (!seen) begin
      check("frame_timeout", {31'd0, frame_valid}, 32'd1);
      frame_q.delete();
      issue_q.delete();
      frame_ready = 1'b0;
      return;
    end
    if (v.chk_lat) check("frame_latency_12_13", {31'd0, (lat >= 12 && lat <= 13)}, 32'd1);
    if (!v.ready_pre) begin
      for (int i = 0; i < v.ready_delay; i++) begin
        check("frame_valid_hold", {31'd0, frame_valid}, 32'd1);
        tick();
      end
      frame_ready = 1'b1;
    end
    tick();
    frame_ready = 1'b0;
    check("frame_valid_drop", {31'd0, frame_valid}, 32'd0);
    check("busy_drop", {31'd0, busy}, 32'd0);
    check("dec_pulses", issue_count, int'(v.rounds) * 3);
    if (v.y_delay > 0) check("y_req_cycles", req_y_cnt, int'(v.rounds) * (1 + v.y_delay));
    check("issue_q_drained", issue_q.size(), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;
    vecs[0] = mk(4'd1, 4'b0001, 4'b0000, 4'b1111, 0, 0, 1'b1, 1'b1, 5'b10000, 5'b00010, 4'd0);
    vecs[1] = mk(4'd1, 4'b0000, 4'b1101, 4'b0000, 0, 0, 1'b0, 1'b1, 5'b01000, 5'b01000, 4'd0);
    vecs[2] = mk(4'd2, 4'b0011, 4'b0000, 4'b0000, 0, 2, 1'b0, 1'b0, 5'b00000, 5'b00000, 4'd0);
    vecs[3] = mk(4'd1, 4'b1111, 4'b0000, 4'b0000, 5, 10, 1'b0, 1'b0, 5'b00000, 5'b00000, 4'd1);
    vecs[4] = mk(4'd3, 4'b1000, 4'b1110, 4'b0111, 0, 1, 1'b0, 1'b0, 5'b01100, 5'b00101, 4'd0);
    vecs[5] = mk(4'd6, 4'b0101, 4'b0101, 4'b0101, 0, 0, 1'b0, 1'b0, 5'b00000, 5'b00000, 4'd15);
    for (int i = 0; i < 4; i++) syn_tab[i] = 4'd0;

    repeat (3) tick();
    RST = 1'b0;
    check_all_zero("reset");

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort while the Y correction is still in the decoder pipe.
    v = mk(4'd1, 4'b0001, 4'b1101, 4'b0000, 0, 0, 1'b0, 1'b0, 5'b0, 5'b0, 4'd0);
    arm(v);
    rounds = 4'd1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(dec_valid && dec_axis == 2'd1) && n < 100) begin
      tick();
      n++;
    end
    check("abort_reach_y_issue", {31'd0, dec_valid}, 32'd1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_meas_req", {31'd0, meas_req}, 32'd0);
    check("abort_syn_ready", {31'd0, syn_ready}, 32'd0);
    check("abort_dec_valid", {31'd0, dec_valid}, 32'd0);
    repeat (4) tick();
    check("abort_frame_x", {27'd0, frame_x}, 32'b10000);
    check("abort_frame_z", {27'd0, frame_z}, 32'd0);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    issue_q.delete();
    run_vec(mk(4'd1, 4'b0000, 4'b0000, 4'b0111, 0, 0, 1'b0, 1'b1, 5'b00000, 5'b00001, 4'd0));

    // start with rounds==0 is ignored.
    rounds = 4'd0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("zero_rounds_busy", {31'd0, busy}, 32'd0);
    check("zero_rounds_meas_req", {31'd0, meas_req}, 32'd0);
    repeat (3) tick();
    check("zero_rounds_busy_later", {31'd0, busy}, 32'd0);
    check("zero_rounds_meas_req_later", {31'd0, meas_req}, 32'd0);

    // RST while stalled in the Y request of round 1.
    v = mk(4'd2, 4'b0001, 4'b0000, 4'b0000, 1000, 0, 1'b0, 1'b0, 5'b0, 5'b0, 4'd0);
    arm(v);
    rounds = 4'd2;
    start  = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(meas_req && meas_axis == 2'd1) && n < 100) begin
      tick();
      n++;
    end
    check("rst_reach_y_req", {30'd0, meas_axis}, 32'd1);
    check("rst_pre_frame_x", {27'd0, frame_x}, 32'b10000);
    RST = 1'b1;
    tick();
    check_all_zero("rst_mid");
    RST = 1'b0;
    issue_q.delete();
    y_delay = 0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
